// File: rtl/bnn_seq_if.sv
// Frame/launch bus between bnn_seq_ctrl and its neighbours (MFCC front end,
// bnn feature buffer and bnn core).
//
// Handshake semantics: mfcc_valid is a one-cycle strobe and is not stalled by
// mfcc_ready. mfcc_ready only advertises that the sequencer is in FILL and
// will store the next frame; a frame strobed while the sequencer is busy is
// dropped and flagged. mfcc_wr_en/mfcc_wr_addr is a plain write port with no
// back-pressure. bnn_start and bnn_done are single-cycle pulses, and
// bnn_result is qualified by bnn_done.
//
// Signals:
//   mfcc_valid   frame strobe from the MFCC front end
//   mfcc_ready   sequencer is filling and accepting frames
//   mfcc_wr_en   feature buffer write strobe
//   mfcc_wr_addr feature buffer frame slot
//   bnn_start    inference launch pulse
//   bnn_done     inference completion pulse
//   bnn_result   class code, valid with bnn_done
// Modports: master = sequencer side, slave = front end / core side.
interface bnn_seq_if #(
  parameter int ADDR_W = 3
);
  logic              mfcc_valid;
  logic              mfcc_ready;
  logic              mfcc_wr_en;
  logic [ADDR_W-1:0] mfcc_wr_addr;
  logic              bnn_start;
  logic              bnn_done;
  logic [1:0]        bnn_result;

  modport master (
    input  mfcc_valid, bnn_done, bnn_result,
    output mfcc_ready, mfcc_wr_en, mfcc_wr_addr, bnn_start
  );

  modport slave (
    output mfcc_valid, bnn_done, bnn_result,
    input  mfcc_ready, mfcc_wr_en, mfcc_wr_addr, bnn_start
  );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// Frame sequencer for the bnn inference core. Collects WIN_FRAMES MFCC frames
// into the core's feature window, launches one inference per full window,
// waits for completion under a cycle timeout, and smooths the speech decision
// into vad_duration using onset/hangover counters.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        level; low forces IDLE and clears counters and vad_duration
//   err_clr       pulse; clears timeout_err and drop_err (a same-cycle set wins)
//   bus           bnn_seq_if master: MFCC frame strobe, feature buffer write
//                 port, bnn start/done/result
//   result        last accepted class code
//   vad_duration  smoothed speech flag
//   busy          high in RUN or WAIT
//   timeout_err   sticky: WAIT expired without bnn_done
//   drop_err      sticky: frame strobed in RUN or WAIT
//   state_dbg     current FSM state (0 IDLE, 1 FILL, 2 RUN, 3 WAIT)
// All outputs come straight from flops.
module bnn_seq_ctrl #(
  parameter int WIN_FRAMES  = 8,
  parameter int ONSET_CNT   = 2,
  parameter int HANG_FRAMES = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       err_clr,
  bnn_seq_if.master  bus,
  output logic [1:0] result,
  output logic       vad_duration,
  output logic       busy,
  output logic       timeout_err,
  output logic       drop_err,
  output logic [1:0] state_dbg
);

  localparam int AW = $clog2(WIN_FRAMES);
  localparam logic [AW-1:0] FCNT_LAST = AW'(WIN_FRAMES - 1);
  localparam logic [15:0]   TCNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]    ONSET_TH  = 4'(ONSET_CNT);
  localparam logic [3:0]    HANG_LOAD = 4'(HANG_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t state, next_state;

  logic [AW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    onset_q, onset_d;
  logic [3:0]    hang_q, hang_d;
  logic [15:0]   tcnt_q, tcnt_d;

  logic          ready_q, ready_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          start_q, start_d;
  logic [1:0]    result_q, result_d;
  logic          vad_q, vad_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          drop_q, drop_d;

  logic          timeout_hit;
  logic [3:0]    onset_inc;

  assign timeout_hit = (tcnt_q == TCNT_LAST);
  assign onset_inc   = (onset_q == 4'd15) ? 4'd15 : onset_q + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: next_state = S_FILL;
        S_FILL: if (bus.mfcc_valid && (fcnt_q == FCNT_LAST)) next_state = S_RUN;
        // RUN holds for the cycle in which bnn_start is high, so WAIT starts
        // the cycle after the launch pulse.
        S_RUN:  if (start_q) next_state = S_WAIT;
        S_WAIT: if (bus.bnn_done || timeout_hit) next_state = S_FILL;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    fcnt_d    = fcnt_q;
    onset_d   = onset_q;
    hang_d    = hang_q;
    tcnt_d    = tcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    start_d   = 1'b0;
    result_d  = result_q;
    vad_d     = vad_q;

    // Ready rises one cycle after FILL is entered and drops as soon as the
    // window-completing frame is seen.
    ready_d = (state == S_FILL) && (next_state == S_FILL);
    busy_d  = (next_state == S_RUN) || (next_state == S_WAIT);

    // Sticky errors: a set in the same cycle as err_clr wins.
    drop_d = (bus.mfcc_valid && ((state == S_RUN) || (state == S_WAIT)))
             || (drop_q && !err_clr);
    terr_d = (enable && (state == S_WAIT) && timeout_hit && !bus.bnn_done)
             || (terr_q && !err_clr);

    if (!enable) begin
      fcnt_d  = '0;
      onset_d = 4'd0;
      hang_d  = 4'd0;
      tcnt_d  = 16'd0;
      vad_d   = 1'b0;
    end else begin
      case (state)
        S_IDLE: fcnt_d = '0;
        S_FILL: begin
          if (bus.mfcc_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = fcnt_q;
            fcnt_d    = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + AW'(1);
          end
        end
        S_RUN: begin
          start_d = !start_q;
          tcnt_d  = 16'd0;
        end
        S_WAIT: begin
          if (bus.bnn_done) begin
            result_d = bus.bnn_result;
            fcnt_d   = '0;
            if (bus.bnn_result == 2'b01) begin
              onset_d = onset_inc;
              hang_d  = HANG_LOAD;
              if (onset_inc >= ONSET_TH) vad_d = 1'b1;
            end else begin
              // Any non-speech code (including reserved 11) eats hangover.
              onset_d = 4'd0;
              if (vad_q) begin
                if (hang_q == 4'd0) vad_d  = 1'b0;
                else                hang_d = hang_q - 4'd1;
              end
            end
          end else if (timeout_hit) begin
            fcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q    <= '0;
      onset_q   <= 4'd0;
      hang_q    <= 4'd0;
      tcnt_q    <= 16'd0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      start_q   <= 1'b0;
      result_q  <= 2'b00;
      vad_q     <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      fcnt_q    <= fcnt_d;
      onset_q   <= onset_d;
      hang_q    <= hang_d;
      tcnt_q    <= tcnt_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      start_q   <= start_d;
      result_q  <= result_d;
      vad_q     <= vad_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.mfcc_ready   = ready_q;
  assign bus.mfcc_wr_en   = wr_en_q;
  assign bus.mfcc_wr_addr = wr_addr_q;
  assign bus.bnn_start    = start_q;
  assign result           = result_q;
  assign vad_duration     = vad_q;
  assign busy             = busy_q;
  assign timeout_err      = terr_q;
  assign drop_err         = drop_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
module tb_bnn_seq_ctrl;
  localparam int WIN   = 8;
  localparam int ONSET = 2;
  localparam int HANG  = 4;
  localparam int TMO   = 16;
  localparam int AW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic err_clr = 1'b0;
  logic [1:0] result, state_dbg;
  logic vad_duration, busy, timeout_err, drop_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  bnn_seq_if #(.ADDR_W(AW)) bus ();

  bnn_seq_ctrl #(
    .WIN_FRAMES (WIN),
    .ONSET_CNT  (ONSET),
    .HANG_FRAMES(HANG),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .bus         (bus),
    .result      (result),
    .vad_duration(vad_duration),
    .busy        (busy),
    .timeout_err (timeout_err),
    .drop_err    (drop_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  res;
    logic        vad;
    logic        terr;
  } end_t;

  logic [AW-1:0] exp_q[$];        // expected write addresses
  logic [31:0]   exp_start_q[$];  // expected bnn_start cycles
  end_t          exp_end_q[$];    // expected state at each busy falling edge

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_end(input int c, input logic [1:0] res, input logic vad, input logic terr);
    end_t e;
    e.cyc  = 32'(c);
    e.res  = res;
    e.vad  = vad;
    e.terr = terr;
    exp_end_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic prev_busy = 1'b0;
  end_t mon_e;
  always @(negedge clk) begin
    if (bus.mfcc_wr_en) begin
      check("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("wr_addr", 32'(bus.mfcc_wr_addr), 32'(exp_q.pop_front()));
    end
    if (bus.bnn_start) begin
      check("start_expected", 32'(exp_start_q.size() > 0), 1);
      if (exp_start_q.size() > 0) check("start_cycle", cyc, exp_start_q.pop_front());
    end
    if (prev_busy && !busy) begin
      check("end_expected", 32'(exp_end_q.size() > 0), 1);
      if (exp_end_q.size() > 0) begin
        mon_e = exp_end_q.pop_front();
        check("end_cycle", cyc, mon_e.cyc);
        check("result", 32'(result), 32'(mon_e.res));
        check("vad_duration", 32'(vad_duration), 32'(mon_e.vad));
        check("timeout_err", 32'(timeout_err), 32'(mon_e.terr));
      end
    end
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.mfcc_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(bus.mfcc_ready), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   32'(bus.mfcc_ready), 0);
    check({tag, "_wr_en"},   32'(bus.mfcc_wr_en), 0);
    check({tag, "_wr_addr"}, 32'(bus.mfcc_wr_addr), 0);
    check({tag, "_start"},   32'(bus.bnn_start), 0);
    check({tag, "_result"},  32'(result), 0);
    check({tag, "_vad"},     32'(vad_duration), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_terr"},    32'(timeout_err), 0);
    check({tag, "_drop"},    32'(drop_err), 0);
    check({tag, "_state"},   32'(state_dbg), 0);
  endtask

  // Strobe WIN back-to-back frames; returns the cycle WAIT is entered.
  task automatic fill_window(output int w);
    int last_t = 0;
    for (int i = 0; i < WIN; i++) begin
      exp_q.push_back(AW'(i));
      bus.mfcc_valid = 1'b1;
      last_t = cyc;
      tick();
    end
    bus.mfcc_valid = 1'b0;
    exp_start_q.push_back(32'(last_t + 2));
    w = last_t + 3;
  endtask

  // One full window followed by bnn_done on the first WAIT cycle.
  task automatic do_window(input logic [1:0] res, input logic exp_vad, input logic exp_terr);
    int w;
    fill_window(w);
    while (cyc < w) tick();
    check("busy_in_wait", 32'(busy), 1);
    check("ready_low_in_wait", 32'(bus.mfcc_ready), 0);
    push_end(cyc + 1, res, exp_vad, exp_terr);
    bus.bnn_done = 1'b1;
    bus.bnn_result = res;
    tick();
    bus.bnn_done = 1'b0;
    wait_ready();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bus.mfcc_valid = 1'b0;
    bus.bnn_done   = 1'b0;
    bus.bnn_result = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    wait_ready();

    // Onset: two speech decisions raise the flag.
    do_window(2'b01, 1'b0, 1'b0);
    do_window(2'b01, 1'b1, 1'b0);
    // Hangover with a speech reload after the third silence.
    do_window(2'b00, 1'b1, 1'b0);
    do_window(2'b00, 1'b1, 1'b0);
    do_window(2'b00, 1'b1, 1'b0);
    do_window(2'b01, 1'b1, 1'b0);
    do_window(2'b00, 1'b1, 1'b0);
    do_window(2'b00, 1'b1, 1'b0);
    do_window(2'b11, 1'b1, 1'b0);
    do_window(2'b10, 1'b1, 1'b0);
    do_window(2'b00, 1'b0, 1'b0);

    // Timeout with no bnn_done.
    fill_window(w);
    push_end(w + TMO, 2'b00, 1'b0, 1'b1);
    while (cyc < w + TMO + 1) tick();
    check("timeout_state_fill", 32'(state_dbg), 1);
    bus.bnn_done = 1'b1;
    bus.bnn_result = 2'b01;
    tick();
    bus.bnn_done = 1'b0;
    check("late_done_ignored", 32'(result), 32'(2'b00));
    check("late_done_no_busy", 32'(busy), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("timeout_err_cleared", 32'(timeout_err), 0);
    wait_ready();

    // Dropped frame in WAIT (with err_clr in the same cycle) and done on expiry.
    fill_window(w);
    while (cyc < w + 2) tick();
    bus.mfcc_valid = 1'b1;
    err_clr = 1'b1;
    tick();
    bus.mfcc_valid = 1'b0;
    err_clr = 1'b0;
    check("drop_err_set_wins", 32'(drop_err), 1);
    check("busy_after_drop", 32'(busy), 1);
    while (cyc < w + TMO - 1) tick();
    push_end(w + TMO, 2'b01, 1'b0, 1'b0);
    bus.bnn_done = 1'b1;
    bus.bnn_result = 2'b01;
    tick();
    bus.bnn_done = 1'b0;
    check("expiry_done_no_terr", 32'(timeout_err), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("drop_err_cleared", 32'(drop_err), 0);
    wait_ready();

    // Second speech decision raises the flag again.
    do_window(2'b01, 1'b1, 1'b0);

    // enable low in WAIT: IDLE next cycle, flag cleared, result held.
    fill_window(w);
    while (cyc < w + 2) tick();
    check("vad_before_disable", 32'(vad_duration), 1);
    enable = 1'b0;
    push_end(w + 3, 2'b01, 1'b0, 1'b0);
    tick();
    bus.bnn_done = 1'b1;
    bus.bnn_result = 2'b10;
    tick();
    bus.bnn_done = 1'b0;
    check("disable_state_idle", 32'(state_dbg), 0);
    check("disable_result_held", 32'(result), 32'(2'b01));
    check("disable_vad_clear", 32'(vad_duration), 0);
    enable = 1'b1;
    wait_ready();

    // Partial window after re-enable starts at slot 0, then reset mid-FILL.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(AW'(i));
      bus.mfcc_valid = 1'b1;
      tick();
    end
    bus.mfcc_valid = 1'b0;
    tick();
    tick();
    check("addr_before_reset", 32'(bus.mfcc_wr_addr), 2);
    check("state_before_reset", 32'(state_dbg), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();

    check("wr_q_drained", 32'(exp_q.size()), 0);
    check("start_q_drained", 32'(exp_start_q.size()), 0);
    check("end_q_drained", 32'(exp_end_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_seq_ctrl.md
# bnn_seq_ctrl

Frame sequencer between the MFCC front end and the `bnn` inference core. It counts incoming MFCC frames and writes them into the core's feature window, then launches one inference per full window and waits for completion under a timeout. It also smooths the per-window class decision into the `vad_duration` speech flag using onset/hangover counters. It sits beside `bnn_cfg`, which drives `enable` and clears errors.

## Interface
- `WIN_FRAMES`, 8: MFCC frames per inference window (2..256).
- `ONSET_CNT`, 2: consecutive speech decisions required to raise `vad_duration` (1..15).
- `HANG_FRAMES`, 4: non-speech decisions tolerated before dropping `vad_duration` (0..15).
- `TIMEOUT`, 1024: maximum cycles spent in WAIT (2..65535).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: level; 0 forces IDLE.
- `err_clr` in 1: one-cycle pulse; clears both sticky errors.
- `mfcc_valid` in 1: one-cycle strobe; a new frame is present on the MFCC bus.
- `mfcc_ready` out 1: high only in FILL.
- `mfcc_wr_en` out 1: write strobe to the `bnn` feature buffer.
- `mfcc_wr_addr` out clog2(WIN_FRAMES): frame slot being written.
- `bnn_start` out 1: one-cycle launch pulse.
- `bnn_done` in 1: one-cycle completion pulse from the core.
- `bnn_result` in 2: class code.
  - 00: silence.
  - 01: speech.
  - 10: noise.
  - 11: reserved.
- `result` out 2: last accepted class code.
- `vad_duration` out 1: smoothed speech flag.
- `busy` out 1: high in RUN or WAIT.
- `timeout_err` out 1: sticky.
- `drop_err` out 1: sticky.

## Operation
- States: IDLE, FILL, RUN, WAIT. All outputs are registered.
- **Reset:** state IDLE. Every output is 0. The frame count, onset count, hang count and timeout count are all 0.
- **IDLE:** if `enable`=1, go to FILL on the next cycle with the frame count at 0.
- **FILL:**
  - Each `mfcc_valid` asserts `mfcc_wr_en` for one cycle, with `mfcc_wr_addr` equal to the current count, then increments the count.
  - The frame that brings the count to WIN_FRAMES moves the FSM to RUN.
- **RUN:** assert `bnn_start` for one cycle, clear the timeout count, go to WAIT.
- **WAIT:**
  - On `bnn_done`: latch `bnn_result` into `result`, apply one smoothing update, and go to FILL with the frame count at 0.
  - If TIMEOUT cycles elapse with no `bnn_done`: set `timeout_err`, go to FILL. `result` and the smoothing state are unchanged.
- **Dropped frames:** `mfcc_valid` in RUN or WAIT is dropped and sets `drop_err`. It is not written.
- **Smoothing update** (once per accepted decision; speech means code 01):
  - On speech: onset count increments, saturating at 15. Hang count loads HANG_FRAMES. `vad_duration` becomes 1 if the new onset count is at least ONSET_CNT.
  - On any other code: onset count clears. If `vad_duration`=1, then hang count 0 clears `vad_duration`; otherwise hang count decrements.
  - Code 11 is treated as non-speech and is still latched into `result`.
- **Boundaries:**
  - `bnn_done` in the same cycle as timeout expiry: done wins and `timeout_err` is not set.
  - `bnn_done` outside WAIT is ignored.
  - `err_clr` in the same cycle as an error set: set wins.
  - `enable`=0 in any state: IDLE on the next cycle.
    - Frame, onset, hang and timeout counts clear.
    - `vad_duration` clears.
    - Any pending `bnn_done` is ignored.
    - `result` and the sticky error flags are kept.
  - `mfcc_wr_addr` wraps only via the window restart; it never exceeds WIN_FRAMES-1.

## Timing
- `mfcc_valid` at cycle t in FILL: `mfcc_wr_en`/`mfcc_wr_addr` at t+1.
- Last window frame at t: state RUN at t+1, `mfcc_ready` low at t+1, `bnn_start` high at t+2, WAIT from t+3.
  - The `mfcc_valid` at t is still accepted.
  - An `mfcc_valid` at t+1 is dropped.
- `bnn_done` at cycle d: `result`, `vad_duration` and state FILL updated at d+1; `mfcc_ready` high at d+2.
- Timeout: WAIT entered at cycle w; with no done, `timeout_err` is set at w+TIMEOUT and FILL is entered at the same cycle.
- Back-to-back `mfcc_valid` on every cycle is supported in FILL.

## Test plan
- **Nominal window:** reset, `enable`=1, WIN_FRAMES=8, 8 `mfcc_valid` strobes.
  - `mfcc_wr_addr` runs 0..7 with 8 `mfcc_wr_en` pulses.
  - `bnn_start` pulses once, 2 cycles after the 8th strobe.
  - `busy` is high until `bnn_done`.
- **Onset:** ONSET_CNT=2, results 01, 01.
  - `vad_duration` stays 0 after the first decision.
  - `vad_duration` goes to 1 the cycle after the second `bnn_done`.
  - `result`=01.
- **Hangover:** with `vad_duration`=1 and HANG_FRAMES=4, five consecutive 00 decisions.
  - `vad_duration` stays 1 through the 4th decision and goes to 0 after the 5th.
  - An 01 inserted after the 3rd reloads the hang count, and the flag stays 1.
- **Timeout:** TIMEOUT=16, no `bnn_done`.
  - `timeout_err`=1 exactly 16 cycles after WAIT entry; FILL resumes.
  - A `bnn_done` arriving later is ignored.
  - `err_clr` clears the flag.
- **Drop and same-cycle events:** `mfcc_valid` during WAIT gives `drop_err`=1 and no `mfcc_wr_en`. `bnn_done` on the expiry cycle gives the result latched and `timeout_err`=0.
- **Enable/reset mid-operation:**
  - `enable`=0 in WAIT with `vad_duration`=1: IDLE next cycle, `vad_duration`=0, `result` held; a later `bnn_done` is ignored.
  - `rst_n` low mid-FILL: all outputs 0 immediately.
